// File: rtl/xstream_tx_pkg.sv
// Shared definitions for the xstream_tx slice: bus widths, register map and
// STATUS bit positions, plus a helper that packs the STATUS word.
package xstream_tx_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;

    // Register offsets relative to BASE.
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_off_e;

    // STATUS layout, MSB-first: full, empty, ovf, zeros, level.
    localparam int unsigned ST_FULL  = DATA_W - 1;
    localparam int unsigned ST_EMPTY = DATA_W - 2;
    localparam int unsigned ST_OVF   = DATA_W - 3;

    // Level occupies the low bits; caller passes it zero-extended.
    function automatic logic [DATA_W-1:0] status_word(
        input logic              full,
        input logic              empty,
        input logic              ovf,
        input logic [DATA_W-1:0] level
    );
        logic [DATA_W-1:0] w;
        w           = level;
        w[ST_FULL]  = full;
        w[ST_EMPTY] = empty;
        w[ST_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/xfifo_sync.sv
// Synchronous FIFO with push/pop/flush.
// Ports: clk, rst (sync, active-high); push/push_data write side; pop read
// side (ignored when empty); flush empties the queue and wins over push;
// head = word at read pointer; full/empty/level status; drop_c flags a push
// rejected for lack of space in the current cycle.
module xfifo_sync #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  drop_c
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LVL_W-1:0]      count;
    logic                  push_ok;
    logic                  pop_ok;

    // Space is judged on the cycle-start level, so a same-cycle pop never helps.
    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty;
    assign drop_c  = push && full && !flush;
    assign level   = count;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; flush realigns read to write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (pop_ok) begin
                    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                end
                count <= count + LVL_W'(push_ok) - LVL_W'(pop_ok);
            end
        end
    end

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/xstream_tx.sv
// Memory-mapped stream transmitter: bus writes to DATA queue words into a
// FIFO drained on a valid/ready stream port.
// Ports: clk, rst (sync, active-high); data_sel/data_we/data_addr/data_to_wr
// bus request; data_to_rd combinational read data; m_valid/m_data/m_ready
// stream master; irq (only when XSTREAM_TX_IRQ_EN is defined) asserts while
// FIFO level <= THRESH.
// Registers at BASE+0..3: DATA (W), STATUS (R, write clears ovf), CTRL
// (bit0 write flushes), THRESH (R/W with XSTREAM_TX_IRQ_EN, else reads 0).
module xstream_tx
    import xstream_tx_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE       = ADDR_W'('h10),
    parameter int unsigned       DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sel,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_to_wr,
    output logic [DATA_W-1:0] data_to_rd,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
`ifdef XSTREAM_TX_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    logic [ADDR_W-1:0] offset;
    logic              hit;
    reg_off_e          reg_sel;
    logic              push;
    logic              flush;
    logic              clr_ovf;
    logic              drop_c;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;
    logic [DATA_W-1:0] head;
    logic              ovf;

    // Modular subtraction: anything below BASE wraps to a large offset.
    assign offset  = data_addr - BASE;
    assign hit     = data_sel && (offset < ADDR_W'(4));
    assign reg_sel = reg_off_e'(offset[1:0]);
    assign push    = hit && data_we && (reg_sel == REG_DATA);
    assign flush   = hit && data_we && (reg_sel == REG_CTRL) && data_to_wr[0];
    assign clr_ovf = hit && data_we && (reg_sel == REG_STATUS);

    xfifo_sync #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_to_wr),
        .pop       (m_ready),
        .flush     (flush),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .drop_c    (drop_c)
    );

    assign m_valid = !empty;
    assign m_data  = head;

    // Sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop_c) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

`ifdef XSTREAM_TX_IRQ_EN
    logic [LVL_W-1:0] thresh;
    logic             wr_thresh;

    assign wr_thresh = hit && data_we && (reg_sel == REG_THRESH);

    // Low-watermark interrupt, registered from the current level.
    always_ff @(posedge clk) begin
        if (rst) begin
            thresh <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_thresh) begin
                thresh <= data_to_wr[LVL_W-1:0];
            end
            irq <= (level <= thresh);
        end
    end
`endif

    // Combinational read mux; zero outside the decoded window.
    always_comb begin
        data_to_rd = '0;
        if (hit) begin
            case (reg_sel)
                REG_STATUS: data_to_rd = status_word(full, empty, ovf, DATA_W'(level));
                REG_THRESH: begin
`ifdef XSTREAM_TX_IRQ_EN
                    data_to_rd = DATA_W'(thresh);
`else
                    data_to_rd = '0;
`endif
                end
                default:    data_to_rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_xstream_tx.sv
// Self-checking bench for xstream_tx: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_xstream_tx;
    import xstream_tx_pkg::*;

    localparam logic [7:0] BASE  = 8'h10;
    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              data_sel = 1'b0;
    logic              data_we = 1'b0;
    logic [ADDR_W-1:0] data_addr = '0;
    logic [DATA_W-1:0] data_to_wr = '0;
    logic [DATA_W-1:0] data_to_rd;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready = 1'b0;
`ifdef XSTREAM_TX_IRQ_EN
    logic              irq;
`endif

    always #5 clk = ~clk;

    xstream_tx #(
        .BASE       (BASE),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_sel   (data_sel),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_to_wr (data_to_wr),
        .data_to_rd (data_to_rd),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
`ifdef XSTREAM_TX_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        sel;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        ready;
        logic [31:0] exp_rd;
        logic        exp_valid;
        logic [31:0] exp_mdata;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected STATUS from occupancy and overflow: full, empty, ovf at the top.
    function automatic logic [31:0] st(input int size, input bit ovf_f);
        logic [31:0] w;
        w = 32'(size);
        if (size == DEPTH) w = w | 32'h8000_0000;
        if (size == 0)     w = w | 32'h4000_0000;
        if (ovf_f)         w = w | 32'h2000_0000;
        return w;
    endfunction

    task automatic drive(input logic s, input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic r);
        data_sel   = s;
        data_we    = w;
        data_addr  = a;
        data_to_wr = d;
        m_ready    = r;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, input logic r);
        drive(1'b1, 1'b1, a, d, r);
        tick();
        idle();
    endtask

    task automatic exp_status(input string name, input logic [31:0] exp);
        drive(1'b1, 1'b0, BASE + 8'd1, 32'h0, 1'b0);
        #1;
        check(name, data_to_rd, exp);
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Randomized-run reference model.
    logic [31:0] q[$];
    bit          m_ovf;
    logic [4:0]  m_thresh;
    bit          m_irq;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'h11, 32'h0,  1'b0, 32'h4000_0000, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 8'h10, 32'h11, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 8'h10, 32'h22, 1'b0, 32'h0, 1'b1, 32'h11};
        tbl[3]  = '{1'b1, 1'b1, 8'h10, 32'h33, 1'b0, 32'h0, 1'b1, 32'h11};
        tbl[4]  = '{1'b1, 1'b0, 8'h11, 32'h0,  1'b0, 32'h3,  1'b1, 32'h11};
        tbl[5]  = '{1'b1, 1'b0, 8'h10, 32'h0,  1'b1, 32'h0, 1'b1, 32'h11};
        tbl[6]  = '{1'b0, 1'b0, 8'h11, 32'h0,  1'b1, 32'h0, 1'b1, 32'h22};
        tbl[7]  = '{1'b1, 1'b0, 8'h15, 32'h0,  1'b1, 32'h0, 1'b1, 32'h33};
        tbl[8]  = '{1'b1, 1'b0, 8'h11, 32'h0,  1'b0, 32'h4000_0000, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 8'h0F, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 8'h12, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 8'h13, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b1, 8'h10, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 1'b1, 8'h12, 32'h2,  1'b0, 32'h0, 1'b1, 32'h44};
        tbl[14] = '{1'b1, 1'b0, 8'h11, 32'h0,  1'b0, 32'h1,  1'b1, 32'h44};
        tbl[15] = '{1'b1, 1'b1, 8'h12, 32'h1,  1'b0, 32'h0, 1'b1, 32'h44};
        tbl[16] = '{1'b1, 1'b0, 8'h11, 32'h0,  1'b0, 32'h4000_0000, 1'b0, 32'h0};

        // Reset held for two cycles.
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("reset_m_valid", 32'(m_valid), 32'h0);

        // Directed table: check read data and stream port before each edge.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ready);
            #1;
            check($sformatf("tbl%0d_rd", i), data_to_rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d_mdata", i), m_data, tbl[i].exp_mdata);
            end
            tick();
        end
        idle();

        // Overfill, then flush concurrent with a pop; ovf must survive the flush.
        for (int i = 0; i < 17; i++) bus_wr(BASE, 32'h100 + 32'(i), 1'b0);
        exp_status("overfill_status", 32'hA000_0010);
        check("overfill_head", m_data, 32'h100);
        bus_wr(BASE + 8'd2, 32'h1, 1'b1);
        check("flush_pop_valid", 32'(m_valid), 32'h0);
        exp_status("flush_pop_status", 32'h6000_0000);
        bus_wr(BASE + 8'd1, 32'h0, 1'b0);
        exp_status("ovf_clear", 32'h4000_0000);

        // Full FIFO: push and pop together -> push rejected.
        for (int i = 0; i < 16; i++) bus_wr(BASE, 32'h200 + 32'(i), 1'b0);
        exp_status("full_status", 32'h8000_0010);
        bus_wr(BASE, 32'hDEAD, 1'b1);
        exp_status("full_pushpop_status", 32'h2000_000F);
        m_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_%0d", i), m_data, 32'h200 + 32'(i));
            tick();
        end
        m_ready = 1'b0;
        check("drain_empty_valid", 32'(m_valid), 32'h0);
        bus_wr(BASE + 8'd1, 32'h0, 1'b0);

        // Level 5, flush then push back-to-back.
        for (int i = 0; i < 5; i++) bus_wr(BASE, 32'h300 + 32'(i), 1'b0);
        exp_status("level5_status", 32'h5);
        bus_wr(BASE + 8'd2, 32'h1, 1'b0);
        check("flush_valid", 32'(m_valid), 32'h0);
        exp_status("flush_status", 32'h4000_0000);
        bus_wr(BASE, 32'h77, 1'b0);
        exp_status("post_flush_status", 32'h1);
        check("post_flush_head", m_data, 32'h77);

        // Reset mid-transfer with the consumer ready.
        bus_wr(BASE, 32'h88, 1'b0);
        m_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ready = 1'b0;
        check("midreset_valid", 32'(m_valid), 32'h0);
        exp_status("midreset_status", 32'h4000_0000);
`ifdef XSTREAM_TX_IRQ_EN
        check("midreset_irq", 32'(irq), 32'h0);

        // Low-watermark interrupt while draining from level 4 with THRESH=2.
        bus_wr(BASE + 8'd3, 32'h2, 1'b0);
        drive(1'b1, 1'b0, BASE + 8'd3, 32'h0, 1'b0);
        #1;
        check("thresh_read", data_to_rd, 32'h2);
        idle();
        for (int i = 0; i < 4; i++) bus_wr(BASE, 32'h400 + 32'(i), 1'b0);
        tick();
        check("irq_level4", 32'(irq), 32'h0);
        m_ready = 1'b1;
        tick();
        check("irq_level3", 32'(irq), 32'h0);
        tick();
        check("irq_level2_same_cycle", 32'(irq), 32'h0);
        tick();
        check("irq_after_level2", 32'(irq), 32'h1);
        m_ready = 1'b0;
`endif

        // Randomized run against the queue model.
        do_reset();
        q.delete();
        m_ovf = 1'b0;
        m_thresh = '0;
        m_irq = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            int          r;
            int          off;
            int          sz;
            logic        s;
            logic        w;
            logic [7:0]  a;
            logic [31:0] d;
            logic        rdy;
            logic [31:0] exp_rd;
            bit          hit;
            bit          pop;
            bit          irq_next;

            r = $urandom_range(0, 99);
            d = $urandom;
            s = 1'b1;
            w = 1'b1;
            if (r < 50)      a = BASE;
            else if (r < 65) begin a = BASE + 8'd1; w = 1'b0; end
            else if (r < 70) a = BASE + 8'd1;
            else if (r < 73) a = BASE + 8'd2;
            else if (r < 78) begin a = BASE + 8'd3; d = 32'($urandom_range(0, 20)); end
            else begin
                a = 8'($urandom_range(32'(BASE) - 2, 32'(BASE) + 5));
                w = 1'($urandom_range(0, 1));
                s = 1'($urandom_range(0, 3) != 0);
            end
            if (n < 1000) rdy = ($urandom_range(0, 9) < 3);
            else          rdy = ($urandom_range(0, 9) < 7);

            drive(s, w, a, d, rdy);
            #1;

            off = int'(a) - int'(BASE);
            hit = s && off >= 0 && off <= 3;
            sz  = q.size();
            exp_rd = 32'h0;
            if (hit && off == 1) exp_rd = st(sz, m_ovf);
`ifdef XSTREAM_TX_IRQ_EN
            if (hit && off == 3) exp_rd = 32'(m_thresh);
            check("rnd_irq", 32'(irq), 32'(m_irq));
`endif
            check("rnd_rd", data_to_rd, exp_rd);
            check("rnd_valid", 32'(m_valid), 32'(sz != 0));
            if (sz != 0) check("rnd_mdata", m_data, q[0]);

            pop = (sz != 0) && rdy;
            irq_next = (sz <= int'(m_thresh));
            if (hit && w && off == 2 && d[0]) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (hit && w && off == 0) begin
                    if (sz < DEPTH) q.push_back(d);
                    else            m_ovf = 1'b1;
                end
            end
            if (hit && w && off == 1) m_ovf = 1'b0;
`ifdef XSTREAM_TX_IRQ_EN
            if (hit && w && off == 3) m_thresh = d[4:0];
`endif
            m_irq = irq_next;
            tick();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
